// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, error codes and common
// keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        CLOCKING  = 3'd3,
        ACK_CHECK = 3'd4,
        RELEASE   = 3'd5
    } ps2_state_e;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads, plus a falling-edge
// strobe on the synced clock line. Shared with the keyboard receiver.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fe
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Idle bus level is high, so reset to 1 to avoid a false edge on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_in};
            data_ff  <= {data_ff[0], data_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];
    assign clk_fe    = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving the open-drain lines through
// active-high pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    ps2_state_e       state;
    logic [INH_W-1:0] inh_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_next;
    logic [8:0]       shift;
    logic             ack_bit;
    logic             clk_sync;
    logic             data_sync;
    logic             clk_fe;
    logic             wd_expired;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fe    (clk_fe)
    );

    assign bit_next   = bit_cnt + 4'd1;
    assign wd_expired = ((state == CLOCKING) || (state == RELEASE)) &&
                        (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign tx_ready   = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            inh_cnt     <= '0;
            wd_cnt      <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            ack_bit     <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            // Timeout has priority over any edge seen in the same cycle.
            if (wd_expired) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_err      <= 1'b1;
                err_code    <= ERR_TIMEOUT;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            shift      <= {odd_parity(tx_data), tx_data};
                            inh_cnt    <= INH_W'(INHIBIT_CYCLES - 1);
                            ps2_clk_oe <= 1'b1;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == '0) begin
                            ps2_data_oe <= 1'b1;
                            state       <= START;
                        end else begin
                            inh_cnt <= inh_cnt - 1'b1;
                        end
                    end
                    START: begin
                        ps2_clk_oe <= 1'b0;
                        wd_cnt     <= '0;
                        bit_cnt    <= '0;
                        state      <= CLOCKING;
                    end
                    CLOCKING: begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (clk_fe) begin
                            bit_cnt <= bit_next;
                            if (bit_next <= 4'd9) begin
                                // Data bits LSB first, then parity from shift[8].
                                ps2_data_oe <= ~shift[0];
                                shift       <= {1'b0, shift[8:1]};
                            end else if (bit_next == 4'd10) begin
                                ps2_data_oe <= 1'b0;
                            end else begin
                                ack_bit <= data_sync;
                                state   <= ACK_CHECK;
                            end
                        end
                    end
                    ACK_CHECK: begin
                        if (!ack_bit) begin
                            state <= RELEASE;
                        end else begin
                            tx_err   <= 1'b1;
                            err_code <= ERR_NACK;
                            state    <= IDLE;
                        end
                    end
                    RELEASE: begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (clk_sync && data_sync) begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the bus.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 50;
    localparam int TO  = 2000;
    localparam int HI  = 8;
    localparam int LO  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err;
    logic [1:0] err_code;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .err_code    (err_code)
    );

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         done_cnt = 0, err_cnt = 0;
    int         done_cyc = -1, rise_cyc = -1;
    int         hi_run = 0, last_hi = 0;
    logic [1:0] last_code = 2'b00;
    logic       hi_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (tx_err) begin
            err_cnt   <= err_cnt + 1;
            last_code <= err_code;
        end
        if (ps2_clk_oe) begin
            hi_run <= hi_run + 1;
            if (!hi_prev) rise_cyc <= cyc;
        end else if (hi_prev) begin
            last_hi <= hi_run;
            hi_run  <= 0;
        end
        hi_prev <= ps2_clk_oe;
    end

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        logic [10:0] exp_frame;
        int          exp_done;
        int          exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit hold, input logic [7:0] d2);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        chk("ready_before_accept", int'(tx_ready), 1);
        @(posedge clk);
        #1;
        chk("clk_oe_after_accept", int'(ps2_clk_oe), 1);
        chk("busy_after_accept", int'(busy), 1);
        @(negedge clk);
        if (hold) tx_data = d2;
        else tx_valid = 1'b0;
    endtask

    // Device side: waits out the inhibit, then clocks 11 bits, sampling on
    // clock high and optionally pulling data low for the ACK.
    task automatic device(input bit ack, input int abort_at, output logic [10:0] frame);
        int t;
        frame = '0;
        t = 0;
        while (ps2_clk_oe !== 1'b1 && t < INH * 4) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (ps2_clk_oe !== 1'b0 && t < INH * 4) begin
            @(negedge clk);
            t++;
        end
        chk("inhibit_release", int'(ps2_clk_oe), 0);
        repeat (4) @(negedge clk);
        frame[0] = ps2_data_in;
        for (int k = 1; k <= 11; k++) begin
            repeat (HI) @(negedge clk);
            if (k == 11 && ack) dev_data_low = 1'b1;
            repeat (2) @(negedge clk);
            dev_clk_low = 1'b1;
            if (k == abort_at) begin
                repeat (5) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                chk("rst_clk_oe", int'(ps2_clk_oe), 0);
                chk("rst_data_oe", int'(ps2_data_oe), 0);
                chk("rst_tx_ready", int'(tx_ready), 1);
                chk("rst_busy", int'(busy), 0);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            repeat (LO) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk);
            if (k <= 10) frame[k] = ps2_data_in;
        end
        repeat (4) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("return_to_idle", int'(tx_ready), 1);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [10:0] fr;
        int d0, e0, t, cnt;

        vecs[0] = '{CMD_SET_LED, 1'b1, 11'h7DA, 1, 0, 2'b00};
        vecs[1] = '{CMD_ENABLE,  1'b1, 11'h5E8, 1, 0, 2'b00};
        vecs[2] = '{8'h00,       1'b1, 11'h600, 1, 0, 2'b00};
        vecs[3] = '{CMD_RESET,   1'b1, 11'h7FE, 1, 0, 2'b00};
        vecs[4] = '{CMD_ENABLE,  1'b0, 11'h5E8, 0, 1, ERR_NACK};

        repeat (3) @(negedge clk);
        chk("reset_clk_oe", int'(ps2_clk_oe), 0);
        chk("reset_data_oe", int'(ps2_data_oe), 0);
        chk("reset_tx_ready", int'(tx_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_tx_done", int'(tx_done), 0);
        chk("reset_tx_err", int'(tx_err), 0);
        chk("reset_err_code", int'(err_code), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send(vecs[i].data, 1'b0, 8'h00);
            device(vecs[i].ack, 0, fr);
            wait_idle();
            chk($sformatf("frame_%0d", i), int'(fr), int'(vecs[i].exp_frame));
            chk($sformatf("inhibit_len_%0d", i), last_hi, INH + 1);
            chk($sformatf("done_pulses_%0d", i), done_cnt - d0, vecs[i].exp_done);
            chk($sformatf("err_pulses_%0d", i), err_cnt - e0, vecs[i].exp_err);
            if (vecs[i].exp_err != 0)
                chk($sformatf("err_code_%0d", i), int'(last_code), int'(vecs[i].exp_code));
            chk($sformatf("clk_oe_end_%0d", i), int'(ps2_clk_oe), 0);
            chk($sformatf("data_oe_end_%0d", i), int'(ps2_data_oe), 0);
        end

        // Timeout: the device never clocks after START.
        d0 = done_cnt;
        send(8'h00, 1'b0, 8'h00);
        t = 0;
        while (ps2_clk_oe && t < INH * 4) begin
            @(posedge clk);
            #1;
            t++;
        end
        cnt = 0;
        while (!tx_err && cnt < TO + 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("timeout_latency", cnt, TO);
        chk("timeout_err_code", int'(err_code), int'(ERR_TIMEOUT));
        chk("timeout_clk_oe", int'(ps2_clk_oe), 0);
        chk("timeout_data_oe", int'(ps2_data_oe), 0);
        chk("timeout_tx_ready", int'(tx_ready), 1);
        repeat (4) @(negedge clk);
        chk("timeout_no_done", done_cnt - d0, 0);

        // Reset at the fifth device clock edge, then a clean 0xFF.
        d0 = done_cnt;
        e0 = err_cnt;
        send(CMD_SET_LED, 1'b0, 8'h00);
        device(1'b1, 5, fr);
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_err", err_cnt - e0, 0);
        d0 = done_cnt;
        send(CMD_RESET, 1'b0, 8'h00);
        device(1'b1, 0, fr);
        wait_idle();
        chk("post_reset_frame", int'(fr), 32'h7FE);
        chk("post_reset_done", done_cnt - d0, 1);

        // Back-pressure: 0x11 held on tx_valid throughout a 0xED frame.
        d0 = done_cnt;
        send(CMD_SET_LED, 1'b1, 8'h11);
        device(1'b1, 0, fr);
        chk("bp_first_frame", int'(fr), 32'h7DA);
        t = 0;
        while (!(done_cnt > d0 && rise_cyc > done_cyc) && t < 100) begin
            @(negedge clk);
            t++;
        end
        tx_valid = 1'b0;
        chk("bp_accept_after_done", rise_cyc - done_cyc, 1);
        device(1'b1, 0, fr);
        wait_idle();
        chk("bp_second_frame", int'(fr), 32'h622);
        chk("bp_done_pulses", done_cnt - d0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
